// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding for the RV32I EX stage.
// Captures decoded ID fields, inserts bubbles on load-use stall or flush, and forwards ALU operands.
module ex_operand_stage (
  input  logic        clk,
  input  logic        rstn,
  input  logic        id_valid,
  input  logic [31:0] id_PC,
  input  logic [31:0] id_rd1,
  input  logic [31:0] id_rd2,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic [4:0]  id_ALUOp,
  input  logic        id_ALUSrc,
  input  logic        id_RegWrite,
  input  logic        id_MemRead,
  input  logic        id_MemWrite,
  input  logic [1:0]  id_WDSel,
  input  logic        flush,
  input  logic        exmem_RegWrite,
  input  logic [4:0]  exmem_rd,
  input  logic [31:0] exmem_result,
  input  logic        memwb_RegWrite,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] memwb_wdata,
  output logic        stall,
  output logic        ex_valid,
  output logic [31:0] ex_A,
  output logic [31:0] ex_B,
  output logic [4:0]  ex_ALUOp,
  output logic [31:0] ex_PC,
  output logic [31:0] ex_store_data,
  output logic [4:0]  ex_rd,
  output logic        ex_RegWrite,
  output logic        ex_MemRead,
  output logic        ex_MemWrite,
  output logic [1:0]  ex_WDSel
);

  logic        vld_p1;
  logic [31:0] pc_p1;
  logic [31:0] rd1_p1;
  logic [31:0] rd2_p1;
  logic [31:0] imm_p1;
  logic [4:0]  rs1_p1;
  logic [4:0]  rs2_p1;
  logic [4:0]  rd_p1;
  logic [4:0]  aluop_p1;
  logic        alusrc_p1;
  logic        regwrite_p1;
  logic        memread_p1;
  logic        memwrite_p1;
  logic [1:0]  wdsel_p1;

  logic [31:0] cap_rd1;
  logic [31:0] cap_rd2;
  logic        bubble;
  logic [31:0] fwd_rs1;
  logic [31:0] fwd_rs2;

  function automatic logic [31:0] wb_bypass(
    input logic [4:0]  rs,
    input logic [31:0] rf_val,
    input logic        wb_we,
    input logic [4:0]  wb_rd,
    input logic [31:0] wb_val
  );
    if (wb_we && wb_rd != 5'd0 && wb_rd == rs)
      return wb_val;
    return rf_val;
  endfunction

  function automatic logic [31:0] forward(
    input logic [4:0]  rs,
    input logic [31:0] base,
    input logic        mem_we,
    input logic [4:0]  mem_rd,
    input logic [31:0] mem_val,
    input logic        wb_we,
    input logic [4:0]  wb_rd,
    input logic [31:0] wb_val
  );
    if (mem_we && mem_rd != 5'd0 && mem_rd == rs)
      return mem_val;
    if (wb_we && wb_rd != 5'd0 && wb_rd == rs)
      return wb_val;
    return base;
  endfunction

  // ID side: capture-time bypass of the register file write happening this cycle
  assign cap_rd1 = wb_bypass(id_rs1, id_rd1, memwb_RegWrite, memwb_rd, memwb_wdata);
  assign cap_rd2 = wb_bypass(id_rs2, id_rd2, memwb_RegWrite, memwb_rd, memwb_wdata);

  assign stall = vld_p1 & memread_p1 & (rd_p1 != 5'd0) & id_valid &
                 ((id_rs1 == rd_p1) | (id_rs2 == rd_p1)) & ~flush;
  assign bubble = flush | stall;

  // ID/EX register boundary
  always_ff @(posedge clk) begin
    if (!rstn || bubble) begin
      vld_p1      <= 1'b0;
      pc_p1       <= '0;
      rd1_p1      <= '0;
      rd2_p1      <= '0;
      imm_p1      <= '0;
      rs1_p1      <= '0;
      rs2_p1      <= '0;
      rd_p1       <= '0;
      aluop_p1    <= '0;
      alusrc_p1   <= 1'b0;
      regwrite_p1 <= 1'b0;
      memread_p1  <= 1'b0;
      memwrite_p1 <= 1'b0;
      wdsel_p1    <= '0;
    end else begin
      vld_p1      <= id_valid;
      pc_p1       <= id_PC;
      rd1_p1      <= cap_rd1;
      rd2_p1      <= cap_rd2;
      imm_p1      <= id_imm;
      rs1_p1      <= id_rs1;
      rs2_p1      <= id_rs2;
      rd_p1       <= id_rd;
      aluop_p1    <= id_ALUOp;
      alusrc_p1   <= id_ALUSrc;
      regwrite_p1 <= id_RegWrite;
      memread_p1  <= id_MemRead;
      memwrite_p1 <= id_MemWrite;
      wdsel_p1    <= id_WDSel;
    end
  end

  // EX side: operand forwarding, EX/MEM before MEM/WB
  assign fwd_rs1 = forward(rs1_p1, rd1_p1, exmem_RegWrite, exmem_rd, exmem_result,
                           memwb_RegWrite, memwb_rd, memwb_wdata);
  assign fwd_rs2 = forward(rs2_p1, rd2_p1, exmem_RegWrite, exmem_rd, exmem_result,
                           memwb_RegWrite, memwb_rd, memwb_wdata);

  assign ex_valid      = vld_p1;
  assign ex_A          = fwd_rs1;
  assign ex_B          = alusrc_p1 ? imm_p1 : fwd_rs2;
  assign ex_store_data = fwd_rs2;
  assign ex_ALUOp      = aluop_p1;
  assign ex_PC         = pc_p1;
  assign ex_rd         = rd_p1;
  assign ex_RegWrite   = regwrite_p1;
  assign ex_MemRead    = memread_p1;
  assign ex_MemWrite   = memwrite_p1;
  assign ex_WDSel      = wdsel_p1;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: directed hazard scenarios followed by randomized traffic
// checked against a reference model of the EX-stage contents.
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rstn;
  logic        id_valid;
  logic [31:0] id_PC, id_rd1, id_rd2, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd, id_ALUOp;
  logic        id_ALUSrc, id_RegWrite, id_MemRead, id_MemWrite;
  logic [1:0]  id_WDSel;
  logic        flush;
  logic        exmem_RegWrite;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_RegWrite;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_wdata;
  logic        stall, ex_valid;
  logic [31:0] ex_A, ex_B, ex_PC, ex_store_data;
  logic [4:0]  ex_ALUOp, ex_rd;
  logic        ex_RegWrite, ex_MemRead, ex_MemWrite;
  logic [1:0]  ex_WDSel;

  int tests = 0;
  int failed = 0;

  ex_operand_stage dut (
    .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_PC(id_PC),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_ALUOp(id_ALUOp),
    .id_ALUSrc(id_ALUSrc), .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead),
    .id_MemWrite(id_MemWrite), .id_WDSel(id_WDSel), .flush(flush),
    .exmem_RegWrite(exmem_RegWrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_RegWrite(memwb_RegWrite), .memwb_rd(memwb_rd), .memwb_wdata(memwb_wdata),
    .stall(stall), .ex_valid(ex_valid), .ex_A(ex_A), .ex_B(ex_B),
    .ex_ALUOp(ex_ALUOp), .ex_PC(ex_PC), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead),
    .ex_MemWrite(ex_MemWrite), .ex_WDSel(ex_WDSel)
  );

  always #5 clk = ~clk;

  // Reference view of the instruction currently sitting in EX
  typedef struct {
    logic        vld;
    logic [31:0] pc, v1, v2, imm;
    logic [4:0]  rs1, rs2, rd, op;
    logic        src, rw, mr, mw;
    logic [1:0]  wd;
  } ex_t;

  ex_t m, m_next;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic ex_t empty_ex();
    ex_t e;
    e.vld = 0; e.pc = 0; e.v1 = 0; e.v2 = 0; e.imm = 0;
    e.rs1 = 0; e.rs2 = 0; e.rd = 0; e.op = 0;
    e.src = 0; e.rw = 0; e.mr = 0; e.mw = 0; e.wd = 0;
    return e;
  endfunction

  // Value a register index resolves to, given who is writing it right now
  function automatic logic [31:0] resolve(input logic [4:0] idx, input logic [31:0] stored,
                                          input logic use_exmem);
    if (idx == 0) return stored;
    if (use_exmem && exmem_RegWrite && exmem_rd == idx) return exmem_result;
    if (memwb_RegWrite && memwb_rd == idx) return memwb_wdata;
    return stored;
  endfunction

  function automatic logic exp_stall();
    logic uses_load = (id_rs1 == m.rd) || (id_rs2 == m.rd);
    return m.vld && m.mr && (m.rd != 0) && id_valid && uses_load && !flush;
  endfunction

  task automatic clear_inputs();
    rstn = 1; id_valid = 0; id_PC = 0; id_rd1 = 0; id_rd2 = 0; id_imm = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_ALUOp = 0; id_ALUSrc = 0;
    id_RegWrite = 0; id_MemRead = 0; id_MemWrite = 0; id_WDSel = 0; flush = 0;
    exmem_RegWrite = 0; exmem_rd = 0; exmem_result = 0;
    memwb_RegWrite = 0; memwb_rd = 0; memwb_wdata = 0;
  endtask

  task automatic id_instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic [4:0] op, input logic mr, input logic [31:0] pc);
    id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_ALUOp = op;
    id_RegWrite = (rd != 0); id_MemRead = mr; id_PC = pc;
    id_rd1 = 0; id_rd2 = 0; id_imm = 32'h0000_0004; id_ALUSrc = 0;
  endtask

  // Full check of the DUT against the model, then one clock edge with model update
  task automatic cycle();
    logic [31:0] b2;
    logic        st;
    @(negedge clk);
    st = exp_stall();
    b2 = resolve(m.rs2, m.v2, 1'b1);
    chk("stall", {31'b0, stall}, {31'b0, st});
    chk("ex_A", ex_A, resolve(m.rs1, m.v1, 1'b1));
    chk("ex_B", ex_B, m.src ? m.imm : b2);
    chk("ex_store_data", ex_store_data, b2);
    chk("ex_PC", ex_PC, m.pc);
    chk("ex_ctrl", {16'b0, ex_valid, ex_rd, ex_ALUOp, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_WDSel},
        {16'b0, m.vld, m.rd, m.op, m.rw, m.mr, m.mw, m.wd});
    if (!rstn || flush || st) begin
      m_next = empty_ex();
    end else begin
      m_next.vld = id_valid; m_next.pc = id_PC; m_next.imm = id_imm;
      m_next.v1 = resolve(id_rs1, id_rd1, 1'b0);
      m_next.v2 = resolve(id_rs2, id_rd2, 1'b0);
      m_next.rs1 = id_rs1; m_next.rs2 = id_rs2; m_next.rd = id_rd; m_next.op = id_ALUOp;
      m_next.src = id_ALUSrc; m_next.rw = id_RegWrite; m_next.mr = id_MemRead;
      m_next.mw = id_MemWrite; m_next.wd = id_WDSel;
    end
    @(posedge clk);
    #1;
    m = m_next;
  endtask

  initial begin
    clear_inputs();
    rstn = 0;
    @(posedge clk);
    #1;
    m = empty_ex();
    rstn = 1;
    #1;
    chk("reset_valid", {31'b0, ex_valid}, 32'd0);
    chk("reset_A", ex_A, 32'd0);
    chk("reset_PC", ex_PC, 32'd0);

    // Back-to-back ALU dependency through EX/MEM
    id_instr(5'd1, 5'd2, 5'd5, 5'd1, 1'b0, 32'h100);
    id_rd1 = 32'h3; id_rd2 = 32'hD;
    cycle();
    id_instr(5'd5, 5'd3, 5'd6, 5'd2, 1'b0, 32'h104);
    cycle();
    id_valid = 0;
    exmem_RegWrite = 1; exmem_rd = 5'd5; exmem_result = 32'h10;
    #1;
    chk("exmem_fwd_A", ex_A, 32'h10);
    cycle();

    // Double producer: EX/MEM wins
    clear_inputs();
    id_instr(5'd5, 5'd0, 5'd9, 5'd3, 1'b0, 32'h108);
    cycle();
    id_valid = 0;
    exmem_RegWrite = 1; exmem_rd = 5'd5; exmem_result = 32'hAA;
    memwb_RegWrite = 1; memwb_rd = 5'd5; memwb_wdata = 32'hBB;
    #1;
    chk("double_prod_A", ex_A, 32'hAA);
    cycle();

    // Load-use: one stall, one bubble, then MEM/WB forward
    clear_inputs();
    id_instr(5'd1, 5'd0, 5'd7, 5'd0, 1'b1, 32'h200);
    cycle();
    id_instr(5'd1, 5'd7, 5'd8, 5'd1, 1'b0, 32'h204);
    #1;
    chk("loaduse_stall", {31'b0, stall}, 32'd1);
    cycle();
    chk("bubble_valid", {31'b0, ex_valid}, 32'd0);
    chk("bubble_op", {27'b0, ex_ALUOp}, 32'd0);
    chk("bubble_no_stall", {31'b0, stall}, 32'd0);
    cycle();
    id_valid = 0;
    memwb_RegWrite = 1; memwb_rd = 5'd7; memwb_wdata = 32'h1234;
    #1;
    chk("loaduse_B", ex_B, 32'h1234);
    chk("loaduse_valid", {31'b0, ex_valid}, 32'd1);
    cycle();

    // Capture-time WB bypass
    clear_inputs();
    id_instr(5'd3, 5'd0, 5'd4, 5'd1, 1'b0, 32'h300);
    memwb_RegWrite = 1; memwb_rd = 5'd3; memwb_wdata = 32'h55;
    cycle();
    clear_inputs();
    #1;
    chk("capture_bypass_A", ex_A, 32'h55);
    cycle();

    // x0 is never forwarded
    clear_inputs();
    id_instr(5'd0, 5'd0, 5'd4, 5'd1, 1'b0, 32'h400);
    cycle();
    id_valid = 0;
    exmem_RegWrite = 1; exmem_rd = 5'd0; exmem_result = 32'hFFFF;
    memwb_RegWrite = 1; memwb_rd = 5'd0; memwb_wdata = 32'hEEEE;
    #1;
    chk("x0_guard_A", ex_A, 32'd0);
    cycle();

    // Flush together with a load-use hazard
    clear_inputs();
    id_instr(5'd1, 5'd0, 5'd7, 5'd0, 1'b1, 32'h500);
    cycle();
    id_instr(5'd7, 5'd2, 5'd8, 5'd1, 1'b0, 32'h504);
    flush = 1;
    #1;
    chk("flush_stall", {31'b0, stall}, 32'd0);
    cycle();
    chk("flush_valid", {31'b0, ex_valid}, 32'd0);
    chk("flush_regwrite", {31'b0, ex_RegWrite}, 32'd0);

    // Reset asserted during a stall
    clear_inputs();
    id_instr(5'd1, 5'd0, 5'd7, 5'd0, 1'b1, 32'h600);
    cycle();
    id_instr(5'd7, 5'd7, 5'd8, 5'd1, 1'b0, 32'h604);
    rstn = 0;
    cycle();
    chk("rst_mid_stall", {ex_valid, ex_rd, ex_ALUOp, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_WDSel, 15'b0}, 32'd0);
    chk("rst_PC", ex_PC, 32'd0);
    clear_inputs();

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      rstn           = ($urandom_range(0, 49) != 0);
      flush          = ($urandom_range(0, 9) == 0);
      id_valid       = ($urandom_range(0, 4) != 0);
      id_PC          = $urandom;
      id_rd1         = $urandom;
      id_rd2         = $urandom;
      id_imm         = $urandom;
      id_rs1         = 5'($urandom_range(0, 7));
      id_rs2         = 5'($urandom_range(0, 7));
      id_rd          = 5'($urandom_range(0, 7));
      id_ALUOp       = 5'($urandom_range(0, 31));
      id_ALUSrc      = 1'($urandom_range(0, 1));
      id_RegWrite    = 1'($urandom_range(0, 1));
      id_MemRead     = ($urandom_range(0, 2) == 0);
      id_MemWrite    = 1'($urandom_range(0, 1));
      id_WDSel       = 2'($urandom_range(0, 3));
      exmem_RegWrite = 1'($urandom_range(0, 1));
      exmem_rd       = 5'($urandom_range(0, 7));
      exmem_result   = $urandom;
      memwb_RegWrite = 1'($urandom_range(0, 1));
      memwb_rd       = 5'($urandom_range(0, 7));
      memwb_wdata    = $urandom;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
